// File: rtl/fft_pkg.sv
// Shared widths, complex packing types and twiddle constants for the FFT datapath.
// Complex words pack imag in the upper half and real in the lower half.
package fft_pkg;

  localparam int FFT_DW   = 32;
  localparam int FFT_WW   = 16;
  localparam int FFT_FRAC = 14;

  // Q1.14 unity twiddle component
  localparam logic [FFT_WW-1:0] ONE = 16'h4000;

  typedef struct packed {
    logic signed [FFT_DW-1:0] im;
    logic signed [FFT_DW-1:0] re;
  } cplx_t;

  typedef struct packed {
    logic signed [FFT_WW-1:0] im;
    logic signed [FFT_WW-1:0] re;
  } twid_t;

  function automatic cplx_t cplx_pack(input logic [FFT_DW-1:0] re, input logic [FFT_DW-1:0] im);
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

  function automatic logic [FFT_DW-1:0] cplx_re(input cplx_t c);
    return c.re;
  endfunction

  function automatic logic [FFT_DW-1:0] cplx_im(input cplx_t c);
    return c.im;
  endfunction

endpackage

// File: rtl/ifft_btf_cmul.sv
// Two-stage conjugate complex multiply T = B*conj(W): stage 1 holds the four
// truncated partial products, stage 2 holds T. Both stages advance on en_i.
module cmul_conj
  import fft_pkg::*;
#(
  parameter int DW   = FFT_DW,
  parameter int WW   = FFT_WW,
  parameter int FRAC = FFT_FRAC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [2*DW-1:0] b_i,
  input  logic [2*WW-1:0] w_i,
  output logic [2*DW-1:0] t_o
);

  localparam int PW = DW + WW;

  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
  logic [DW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
  logic [DW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic [DW-1:0] t_re_d, t_im_d;
  logic [DW-1:0] t_re_q, t_im_q;

  // Full-precision products; the DW-wide cast keeps bits [FRAC+DW-1:FRAC].
  always_comb begin
    br_x   = {{WW{b_i[DW-1]}}, b_i[DW-1:0]};
    bi_x   = {{WW{b_i[2*DW-1]}}, b_i[2*DW-1:DW]};
    wr_x   = {{DW{w_i[WW-1]}}, w_i[WW-1:0]};
    wi_x   = {{DW{w_i[2*WW-1]}}, w_i[2*WW-1:WW]};
    p_rr_d = DW'((br_x * wr_x) >>> FRAC);
    p_ii_d = DW'((bi_x * wi_x) >>> FRAC);
    p_ir_d = DW'((bi_x * wr_x) >>> FRAC);
    p_ri_d = DW'((br_x * wi_x) >>> FRAC);
    t_re_d = p_rr_q + p_ii_q;
    t_im_d = p_ir_q - p_ri_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ir_q <= '0;
      p_ri_q <= '0;
      t_re_q <= '0;
      t_im_q <= '0;
    end else if (en_i) begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ir_q <= p_ir_d;
      p_ri_q <= p_ri_d;
      t_re_q <= t_re_d;
      t_im_q <= t_im_d;
    end
  end

  assign t_o = {t_im_q, t_re_q};

endmodule

// File: rtl/ifft_btf.sv
// Inverse DIT radix-2 butterfly, 3-stage pipeline with ready/valid stall.
// Define IFFT_BTF_SCALE_EN to halve both outputs (computed at DW+1 bits, no wrap).
module ifft_btf
  import fft_pkg::*;
#(
  parameter int DW   = FFT_DW,
  parameter int WW   = FFT_WW,
  parameter int FRAC = FFT_FRAC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] din1,
  input  logic [2*DW-1:0] din2,
  input  logic [2*WW-1:0] wn,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] dout1,
  output logic [2*DW-1:0] dout2,
  output logic            out_last
);

  logic            advance;
  logic            v1_q, v2_q, out_valid_q;
  logic            l1_q, l2_q, out_last_q;
  logic [2*DW-1:0] a1_q, a2_q;
  logic [2*DW-1:0] t;
  logic [DW-1:0]   a_re, a_im, t_re, t_im;
  logic [2*DW-1:0] dout1_d, dout2_d, dout1_q, dout2_q;

  // Whole pipeline moves together; a full output slot that is not taken freezes it.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  cmul_conj #(
    .DW  (DW),
    .WW  (WW),
    .FRAC(FRAC)
  ) u_cmul (
    .clk (clk),
    .rst (rst),
    .en_i(advance),
    .b_i (din2),
    .w_i (wn),
    .t_o (t)
  );

  always_comb begin
    a_re    = a2_q[DW-1:0];
    a_im    = a2_q[2*DW-1:DW];
    t_re    = t[DW-1:0];
    t_im    = t[2*DW-1:DW];
    dout1_d = '0;
    dout2_d = '0;
`ifdef IFFT_BTF_SCALE_EN
    dout1_d[DW-1:0]    = DW'(({a_re[DW-1], a_re} + {t_re[DW-1], t_re}) >> 1);
    dout1_d[2*DW-1:DW] = DW'(({a_im[DW-1], a_im} + {t_im[DW-1], t_im}) >> 1);
    dout2_d[DW-1:0]    = DW'(({a_re[DW-1], a_re} - {t_re[DW-1], t_re}) >> 1);
    dout2_d[2*DW-1:DW] = DW'(({a_im[DW-1], a_im} - {t_im[DW-1], t_im}) >> 1);
`else
    dout1_d = {a_im + t_im, a_re + t_re};
    dout2_d = {a_im - t_im, a_re - t_re};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      out_last_q  <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      dout1_q     <= '0;
      dout2_q     <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      l1_q        <= in_valid && in_last;
      a1_q        <= din1;
      v2_q        <= v1_q;
      l2_q        <= l1_q;
      a2_q        <= a1_q;
      out_valid_q <= v2_q;
      out_last_q  <= l2_q;
      dout1_q     <= dout1_d;
      dout2_q     <= dout2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign dout1     = dout1_q;
  assign dout2     = dout2_q;

endmodule

// File: tb/tb_ifft_btf.sv
// Directed self-checking bench for ifft_btf (default DW=32, WW=16, FRAC=14).
module tb_ifft_btf;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [63:0] din1, din2, dout1, dout2;
  logic [31:0] wn;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ifft_btf dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din1     (din1),
    .din2     (din2),
    .wn       (wn),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout1    (dout1),
    .dout2    (dout2),
    .out_last (out_last)
  );

  function automatic logic [63:0] cpx(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {i, r};
  endfunction

  // Reference butterfly from the algebra: truncate each product, wrap T, then A +/- T.
  function automatic logic [127:0] bfly(input logic [63:0] a, input logic [63:0] b, input logic [31:0] w);
    longint      br, bi, wr, wi, ar, ai, tr, ti, s1r, s1i, s2r, s2i;
    logic [31:0] trw, tiw;
    logic [63:0] d1, d2;
    br  = longint'($signed(b[31:0]));
    bi  = longint'($signed(b[63:32]));
    wr  = longint'($signed(w[15:0]));
    wi  = longint'($signed(w[31:16]));
    ar  = longint'($signed(a[31:0]));
    ai  = longint'($signed(a[63:32]));
    tr  = ((br * wr) >>> 14) + ((bi * wi) >>> 14);
    ti  = ((bi * wr) >>> 14) - ((br * wi) >>> 14);
    trw = tr[31:0];
    tiw = ti[31:0];
    s1r = ar + longint'($signed(trw));
    s1i = ai + longint'($signed(tiw));
    s2r = ar - longint'($signed(trw));
    s2i = ai - longint'($signed(tiw));
`ifdef IFFT_BTF_SCALE_EN
    d1 = {s1i[32:1], s1r[32:1]};
    d2 = {s2i[32:1], s2r[32:1]};
`else
    d1 = {s1i[31:0], s1r[31:0]};
    d2 = {s2i[31:0], s2r[31:0]};
`endif
    return {d2, d1};
  endfunction

  function automatic logic [63:0] gen_a(input int k);
    return cpx(1000 * k - 3000, 5 - 7 * k);
  endfunction

  function automatic logic [63:0] gen_b(input int k);
    return cpx(300 + 11 * k, 123456 - 50 * k);
  endfunction

  function automatic logic [31:0] gen_w(input int k);
    case (k % 4)
      0:       return {16'h0000, ONE};
      1:       return 32'hC000_0000;
      2:       return 32'h2D41_2D41;
      default: return 32'h1000_D2BF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    din1     = '0;
    din2     = '0;
    wn       = '0;
  endtask

  task automatic drive_gen(input int k, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    din1     = gen_a(k);
    din2     = gen_b(k);
    wn       = gen_w(k);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b expected 0", out_last); end
    n_tests++; if (dout1 !== 64'd0) begin n_fail++; $display("FAIL rst_dout1: got %h expected 0", dout1); end
    n_tests++; if (dout2 !== 64'd0) begin n_fail++; $display("FAIL rst_dout2: got %h expected 0", dout2); end
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0] ta[5], tb[5], e1[5], e2[5];
    logic [31:0] tw[5];
    ta[0] = cpx(100, 50);         tb[0] = cpx(20, 10); tw[0] = 32'h0000_4000;
    ta[1] = cpx(100, 50);         tb[1] = cpx(20, 10); tw[1] = 32'hC000_0000;
    ta[2] = cpx(32'h7FFF_FFFF, 0); tb[2] = cpx(1, 0);  tw[2] = {16'h0000, ONE};
    ta[3] = cpx(0, 0);            tb[3] = cpx(-3, 0);  tw[3] = 32'h0000_2000;
    ta[4] = cpx(10, 10);          tb[4] = cpx(3, 7);   tw[4] = 32'h4000_0000;
`ifdef IFFT_BTF_SCALE_EN
    e1[0] = cpx(60, 30);           e2[0] = cpx(40, 20);
    e1[1] = cpx(45, 35);           e2[1] = cpx(55, 15);
    e1[2] = cpx(32'h4000_0000, 0); e2[2] = cpx(32'h3FFF_FFFF, 0);
    e1[3] = cpx(-1, 0);            e2[3] = cpx(1, 0);
    e1[4] = cpx(8, 3);             e2[4] = cpx(1, 6);
`else
    e1[0] = cpx(120, 60);          e2[0] = cpx(80, 40);
    e1[1] = cpx(90, 70);           e2[1] = cpx(110, 30);
    e1[2] = cpx(32'h8000_0000, 0); e2[2] = cpx(32'h7FFF_FFFE, 0);
    e1[3] = cpx(-2, 0);            e2[3] = cpx(2, 0);
    e1[4] = cpx(17, 7);            e2[4] = cpx(3, 13);
`endif
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      din1     = ta[i];
      din2     = tb[i];
      wn       = tw[i];
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
      tick();
      idle();
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %b expected 1", i, out_valid); end
      n_tests++; if (dout1 !== e1[i]) begin n_fail++; $display("FAIL dir%0d_dout1: got %h expected %h", i, dout1, e1[i]); end
      n_tests++; if (dout2 !== e2[i]) begin n_fail++; $display("FAIL dir%0d_dout2: got %h expected %h", i, dout2, e2[i]); end
      n_tests++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL dir%0d_last: got %b expected 1", i, out_last); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_single: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int src = 0, n_out = 0, first_c = -1, last_c = -1;
    logic [127:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && n_out < 8; c++) begin
      if (src < 8) drive_gen(src, src == 7);
      else idle();
      #1;
      if (out_valid) begin
        e = bfly(gen_a(n_out), gen_b(n_out), gen_w(n_out));
        if (first_c < 0) first_c = c;
        last_c = c;
        n_tests++; if (dout1 !== e[63:0]) begin n_fail++; $display("FAIL b2b%0d_dout1: got %h expected %h", n_out, dout1, e[63:0]); end
        n_tests++; if (dout2 !== e[127:64]) begin n_fail++; $display("FAIL b2b%0d_dout2: got %h expected %h", n_out, dout2, e[127:64]); end
        n_tests++; if (out_last !== (n_out == 7)) begin n_fail++; $display("FAIL b2b%0d_last: got %b expected %b", n_out, out_last, n_out == 7); end
        n_out++;
      end
      if (in_valid && in_ready) src++;
      tick();
    end
    idle();
    n_tests++; if (n_out !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", n_out); end
    n_tests++; if (first_c !== 3) begin n_fail++; $display("FAIL b2b_latency: got cycle %0d expected 3", first_c); end
    n_tests++; if (last_c - first_c !== 7) begin n_fail++; $display("FAIL b2b_span: got %0d expected 7", last_c - first_c); end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    int src = 0, n_out = 0;
    logic hold = 1'b0, saw_low = 1'b0, hl = 1'b0;
    logic [63:0] h1 = '0, h2 = '0;
    logic [127:0] e;
    for (int c = 0; c < 40 && n_out < 6; c++) begin
      out_ready = !(c >= 3 && c < 8);
      if (src < 6) drive_gen(src + 10, src == 5);
      else idle();
      #1;
      if (hold) begin
        n_tests++;
        if (out_valid !== 1'b1 || dout1 !== h1 || dout2 !== h2 || out_last !== hl) begin
          n_fail++; $display("FAIL bp_hold_c%0d: got %b/%h/%h expected 1/%h/%h", c, out_valid, dout1, dout2, h1, h2);
        end
      end
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        e = bfly(gen_a(n_out + 10), gen_b(n_out + 10), gen_w(n_out + 10));
        n_tests++; if (dout1 !== e[63:0]) begin n_fail++; $display("FAIL bp%0d_dout1: got %h expected %h", n_out, dout1, e[63:0]); end
        n_tests++; if (dout2 !== e[127:64]) begin n_fail++; $display("FAIL bp%0d_dout2: got %h expected %h", n_out, dout2, e[127:64]); end
        n_tests++; if (out_last !== (n_out == 5)) begin n_fail++; $display("FAIL bp%0d_last: got %b expected %b", n_out, out_last, n_out == 5); end
        n_out++;
      end
      hold = out_valid && !out_ready;
      h1   = dout1;
      h2   = dout2;
      hl   = out_last;
      if (in_valid && in_ready) src++;
      tick();
    end
    idle();
    out_ready = 1'b1;
    n_tests++; if (n_out !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", n_out); end
    n_tests++; if (saw_low !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 1", saw_low); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup_c%0d: got %b expected 0", c, out_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    drive_gen(20, 1'b0);
    tick();
    drive_gen(21, 1'b1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flush_c%0d: got %b expected 0", c, out_valid); end
      tick();
    end
    in_valid = 1'b1;
    din1     = cpx(100, 50);
    din2     = cpx(20, 10);
    wn       = 32'hC000_0000;
    tick();
    idle();
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early: got %b expected 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b expected 1", out_valid); end
`ifdef IFFT_BTF_SCALE_EN
    n_tests++; if (dout1 !== cpx(45, 35)) begin n_fail++; $display("FAIL mid_dout1: got %h expected %h", dout1, cpx(45, 35)); end
`else
    n_tests++; if (dout1 !== cpx(90, 70)) begin n_fail++; $display("FAIL mid_dout1: got %h expected %h", dout1, cpx(90, 70)); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
